snes_pad_responder: RTL and testbench

SNES_PAD_RESPONDER -- requirements
Module: snes_pad_responder

---
 rtl/snes_pad_responder_pkg.sv | 41 ++++
 rtl/snes_pad_responder_if.sv | 32 +++
 rtl/pad_input_sync.sv | 79 +++++++
 rtl/snes_pad_responder.sv | 153 +++++++++++++++
 tb/tb_snes_pad_responder.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snes_pad_responder_pkg.sv
// Shared types and helpers for the SNES/NES pad responder, plus the
// configuration package holding button indices and legal frame lengths.
package snes_pad_responder_pkg;

    localparam int BTN_W   = 12;
    localparam int LOAD_W  = 16;
    localparam int CNT_W   = 5;
    localparam int FILT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2
    } frame_state_e;

    // Serial line is active-low; the four slots past the buttons always read released.
    function automatic logic [LOAD_W-1:0] pad_load_word(input logic [BTN_W-1:0] buttons);
        return {{(LOAD_W - BTN_W){1'b1}}, ~buttons};
    endfunction

endpackage

package configPackage;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    localparam int PAD_BITS_SNES = 16;
    localparam int PAD_BITS_NES  = 8;

endpackage

// File: rtl/snes_pad_responder_if.sv
// Console-side pad port: button inputs, the two console pins and status outputs.
interface snes_pad_responder_if;

    logic [snes_pad_responder_pkg::BTN_W-1:0] buttons;
    logic                                     joy_strb;
    logic                                     joy_clk;
    logic                                     joy_data;
    logic                                     polled;
    logic [snes_pad_responder_pkg::CNT_W-1:0] bit_cnt;
    logic                                     active;

    modport master (
        output buttons,
        output joy_strb,
        output joy_clk,
        input  joy_data,
        input  polled,
        input  bit_cnt,
        input  active
    );

    modport slave (
        input  buttons,
        input  joy_strb,
        input  joy_clk,
        output joy_data,
        output polled,
        output bit_cnt,
        output active
    );

endinterface

// File: rtl/pad_input_sync.sv
// Synchronizes one asynchronous console pin, debounces it and flags accepted edges.
module pad_input_sync
    import snes_pad_responder_pkg::*;
#(
    parameter int   FILTER_CYCLES = 2,
    parameter logic IDLE_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    localparam logic [FILT_W-1:0] CNT_LAST = FILT_W'(FILTER_CYCLES - 1);

    logic              sync1_q;
    logic              sync2_q;
    logic              level_q;
    logic              level_d;
    logic              rise_q;
    logic              rise_d;
    logic              fall_q;
    logic              fall_d;
    logic [FILT_W-1:0] cnt_q;
    logic [FILT_W-1:0] cnt_d;

    // Two-flop synchronizer, parked at the pin's idle level so reset never fakes an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= IDLE_LEVEL;
            sync2_q <= IDLE_LEVEL;
        end else begin
            sync1_q <= pin_i;
            sync2_q <= sync1_q;
        end
    end

    // A new level is taken once FILTER_CYCLES consecutive samples disagree with the current one.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                cnt_d   = {FILT_W{1'b0}};
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d   = cnt_q + {{(FILT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            cnt_d = {FILT_W{1'b0}};
        end
    end

    // Filter state and edge pulses, all aligned to the same clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_q <= IDLE_LEVEL;
            cnt_q   <= {FILT_W{1'b0}};
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/snes_pad_responder.sv
// Emulates an SNES/NES controller: latches buttons on strobe, shifts them out
// on the console's clock, and tracks whether a host is still polling.
module snes_pad_responder
    import snes_pad_responder_pkg::*;
    import configPackage::*;
#(
    parameter int PAD_BITS       = PAD_BITS_SNES,
    parameter int FILTER_CYCLES  = 2,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input logic                 clk,
    input logic                 reset,
    snes_pad_responder_if.slave pad
);

    // Anything other than the NES length is treated as a full SNES frame.
    localparam int SR_BITS = (PAD_BITS == PAD_BITS_NES) ? PAD_BITS_NES : PAD_BITS_SNES;
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(SR_BITS);
    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_ONE  = {{(TMR_W-1){1'b0}}, 1'b1};

    logic               strb_lvl_s;
    logic               strb_rise_s;
    logic               strb_fall_s;
    logic               jclk_lvl_s;
    logic               jclk_rise_s;
    logic               jclk_fall_s;
    logic               sync_unused_s;
    logic [SR_BITS-1:0] load_s;

    frame_state_e       state_q;
    frame_state_e       state_d;
    logic [SR_BITS-1:0] sr_q;
    logic [SR_BITS-1:0] sr_d;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [CNT_W-1:0]   bit_cnt_d;
    logic               polled_q;
    logic               polled_d;
    logic [TMR_W-1:0]   timer_q;
    logic [TMR_W-1:0]   timer_d;
    logic               active_q;
    logic               active_d;

    pad_input_sync #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .IDLE_LEVEL    (1'b0)
    ) u_strb_sync (
        .clk     (clk),
        .reset   (reset),
        .pin_i   (pad.joy_strb),
        .level_o (strb_lvl_s),
        .rise_o  (strb_rise_s),
        .fall_o  (strb_fall_s)
    );

    pad_input_sync #(
        .FILTER_CYCLES (FILTER_CYCLES),
        .IDLE_LEVEL    (1'b1)
    ) u_jclk_sync (
        .clk     (clk),
        .reset   (reset),
        .pin_i   (pad.joy_clk),
        .level_o (jclk_lvl_s),
        .rise_o  (jclk_rise_s),
        .fall_o  (jclk_fall_s)
    );

    assign sync_unused_s = strb_rise_s ^ jclk_lvl_s ^ jclk_fall_s;

    if (SR_BITS == PAD_BITS_NES) begin : g_nes
        logic nes_unused_s;
        assign load_s       = ~pad.buttons[PAD_BITS_NES-1:0];
        assign nes_unused_s = ^pad.buttons[BTN_W-1:PAD_BITS_NES];
    end else begin : g_snes
        assign load_s = pad_load_word(pad.buttons);
    end

    // Frame sequencing: strobe reloads and wins over clock; IDLE ignores clocks until the first strobe.
    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        bit_cnt_d = bit_cnt_q;
        if (strb_lvl_s) begin
            state_d   = ST_LOAD;
            sr_d      = load_s;
            bit_cnt_d = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_LOAD, ST_SHIFT: begin
                    state_d = ST_SHIFT;
                    if (jclk_rise_s) begin
                        sr_d      = {1'b0, sr_q[SR_BITS-1:1]};
                        bit_cnt_d = (bit_cnt_q == CNT_SAT) ? bit_cnt_q : bit_cnt_q + 5'd1;
                    end else begin
                        sr_d      = sr_q;
                        bit_cnt_d = bit_cnt_q;
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    sr_d      = {SR_BITS{1'b1}};
                    bit_cnt_d = {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Host-presence timer: reloads after each poll, active drops as it reaches zero.
    always_comb begin
        polled_d = strb_fall_s;
        timer_d  = timer_q;
        active_d = active_q;
        if (polled_q) begin
            timer_d  = TMR_LOAD;
            active_d = 1'b1;
        end else if (timer_q != {TMR_W{1'b0}}) begin
            timer_d  = timer_q - TMR_ONE;
            active_d = (timer_q != TMR_ONE);
        end else begin
            timer_d  = {TMR_W{1'b0}};
            active_d = 1'b0;
        end
    end

    // State registers; the shift register resets to all-released.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sr_q      <= {SR_BITS{1'b1}};
            bit_cnt_q <= {CNT_W{1'b0}};
            polled_q  <= 1'b0;
            timer_q   <= {TMR_W{1'b0}};
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            bit_cnt_q <= bit_cnt_d;
            polled_q  <= polled_d;
            timer_q   <= timer_d;
            active_q  <= active_d;
        end
    end

    assign pad.joy_data = sr_q[0];
    assign pad.polled   = polled_q;
    assign pad.bit_cnt  = bit_cnt_q;
    assign pad.active   = active_q;

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed bench for snes_pad_responder: a 16-bit and an 8-bit instance share
// the console pins and are compared against hand-computed serial frames.
module tb_snes_pad_responder;

    localparam int STRB_CYC   = 12;
    localparam int SETTLE_CYC = 8;
    localparam int HALF_CYC   = 8;

    typedef struct {
        logic [11:0] latch_btn;
        logic [11:0] post_btn;
        int          npulse;
        logic [19:0] exp16;
        logic [19:0] exp8;
        logic [4:0]  cnt16;
        logic [4:0]  cnt8;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        strb_s;
    logic        jclk_s;
    logic [11:0] btn_s;
    int          checks;
    int          failures;
    int          poll16_n;
    int          poll8_n;
    vec_t        vecs [6];

    snes_pad_responder_if if16 ();
    snes_pad_responder_if if8 ();

    assign if16.joy_strb = strb_s;
    assign if16.joy_clk  = jclk_s;
    assign if16.buttons  = btn_s;
    assign if8.joy_strb  = strb_s;
    assign if8.joy_clk   = jclk_s;
    assign if8.buttons   = btn_s;

    snes_pad_responder #(
        .PAD_BITS       (16),
        .FILTER_CYCLES  (2),
        .TIMEOUT_CYCLES (100)
    ) dut16 (
        .clk   (clk),
        .reset (reset),
        .pad   (if16)
    );

    snes_pad_responder #(
        .PAD_BITS       (8),
        .FILTER_CYCLES  (2),
        .TIMEOUT_CYCLES (100)
    ) dut8 (
        .clk   (clk),
        .reset (reset),
        .pad   (if8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (if16.polled) poll16_n <= poll16_n + 1;
        if (if8.polled)  poll8_n  <= poll8_n + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_jclk();
        jclk_s = 1'b0;
        wait_cyc(HALF_CYC);
        jclk_s = 1'b1;
        wait_cyc(HALF_CYC);
    endtask

    task automatic latch(input logic [11:0] b);
        btn_s  = b;
        strb_s = 1'b1;
        wait_cyc(STRB_CYC);
        strb_s = 1'b0;
        wait_cyc(SETTLE_CYC);
    endtask

    task automatic run_vec(input int vi);
        int p16;
        int p8;
        p16    = poll16_n;
        p8     = poll8_n;
        btn_s  = vecs[vi].latch_btn;
        strb_s = 1'b1;
        wait_cyc(STRB_CYC);
        check($sformatf("v%0d_cnt16_in_strobe", vi), 32'(if16.bit_cnt), 32'd0);
        check($sformatf("v%0d_cnt8_in_strobe", vi), 32'(if8.bit_cnt), 32'd0);
        strb_s = 1'b0;
        wait_cyc(SETTLE_CYC);
        btn_s = vecs[vi].post_btn;
        for (int k = 0; k < vecs[vi].npulse; k++) begin
            check($sformatf("v%0d_rd%0d_data16", vi, k), 32'(if16.joy_data), 32'(vecs[vi].exp16[k]));
            check($sformatf("v%0d_rd%0d_data8", vi, k), 32'(if8.joy_data), 32'(vecs[vi].exp8[k]));
            pulse_jclk();
        end
        check($sformatf("v%0d_bitcnt16", vi), 32'(if16.bit_cnt), 32'(vecs[vi].cnt16));
        check($sformatf("v%0d_bitcnt8", vi), 32'(if8.bit_cnt), 32'(vecs[vi].cnt8));
        check($sformatf("v%0d_polled16", vi), 32'(poll16_n - p16), 32'd1);
        check($sformatf("v%0d_polled8", vi), 32'(poll8_n - p8), 32'd1);
    endtask

    initial begin
        int  lat;
        int  p16;
        bit  seen;

        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        strb_s   = 1'b0;
        jclk_s   = 1'b1;
        btn_s    = 12'h000;

        vecs[0] = '{12'h001, 12'h001, 16, 20'h0FFFE, 20'h000FE, 5'd16, 5'd8};
        vecs[1] = '{12'hFFF, 12'hFFF, 20, 20'h0F000, 20'h00000, 5'd16, 5'd8};
        vecs[2] = '{12'h0A5, 12'h0A5, 12, 20'h00F5A, 20'h0005A, 5'd12, 5'd8};
        vecs[3] = '{12'h000, 12'h000, 16, 20'h0FFFF, 20'h000FF, 5'd16, 5'd8};
        vecs[4] = '{12'h001, 12'h800, 16, 20'h0FFFE, 20'h000FE, 5'd16, 5'd8};
        vecs[5] = '{12'h800, 12'h800, 16, 20'h0F7FF, 20'h000FF, 5'd16, 5'd8};

        wait_cyc(3);
        check("rst_data16", 32'(if16.joy_data), 32'd1);
        check("rst_polled16", 32'(if16.polled), 32'd0);
        check("rst_bitcnt16", 32'(if16.bit_cnt), 32'd0);
        check("rst_active16", 32'(if16.active), 32'd0);
        check("rst_data8", 32'(if8.joy_data), 32'd1);
        reset = 1'b0;
        wait_cyc(3);

        for (int vi = 0; vi < 6; vi++) begin
            run_vec(vi);
        end

        // Clock edge while strobe is held high must not shift or count.
        btn_s  = 12'h001;
        strb_s = 1'b1;
        wait_cyc(4);
        jclk_s = 1'b0;
        wait_cyc(4);
        jclk_s = 1'b1;
        wait_cyc(8);
        strb_s = 1'b0;
        wait_cyc(SETTLE_CYC);
        check("prio_bitcnt16", 32'(if16.bit_cnt), 32'd0);
        check("prio_data16", 32'(if16.joy_data), 32'd0);
        check("prio_bitcnt8", 32'(if8.bit_cnt), 32'd0);

        // One-cycle clock glitch is rejected.
        jclk_s = 1'b0;
        wait_cyc(1);
        jclk_s = 1'b1;
        wait_cyc(10);
        check("glitch_data16", 32'(if16.joy_data), 32'd0);
        check("glitch_bitcnt16", 32'(if16.bit_cnt), 32'd0);

        // Three-cycle clock pulse shifts once, five cycles after the rising pin edge.
        jclk_s = 1'b0;
        wait_cyc(3);
        jclk_s = 1'b1;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk);
            #1;
            if (lat == 0 && if16.joy_data == 1'b1) lat = i;
        end
        check("edge_latency16", 32'(lat), 32'd5);
        wait_cyc(2);
        check("short_pulse_bitcnt16", 32'(if16.bit_cnt), 32'd1);
        check("short_pulse_bitcnt8", 32'(if8.bit_cnt), 32'd1);

        // One-cycle strobe glitch: no reload, no poll.
        p16    = poll16_n;
        strb_s = 1'b1;
        wait_cyc(1);
        strb_s = 1'b0;
        wait_cyc(10);
        check("strb_glitch_bitcnt16", 32'(if16.bit_cnt), 32'd1);
        check("strb_glitch_data16", 32'(if16.joy_data), 32'd1);
        check("strb_glitch_polled16", 32'(poll16_n - p16), 32'd0);

        // Reset mid-frame: output stays released until a fresh strobe.
        latch(12'hFFF);
        for (int k = 0; k < 5; k++) pulse_jclk();
        check("pre_rst_data16", 32'(if16.joy_data), 32'd0);
        check("pre_rst_bitcnt16", 32'(if16.bit_cnt), 32'd5);
        reset = 1'b1;
        #1;
        check("async_rst_data16", 32'(if16.joy_data), 32'd1);
        check("async_rst_bitcnt16", 32'(if16.bit_cnt), 32'd0);
        check("async_rst_active16", 32'(if16.active), 32'd0);
        check("async_rst_data8", 32'(if8.joy_data), 32'd1);
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
        for (int k = 0; k < 3; k++) begin
            pulse_jclk();
            check($sformatf("post_rst_p%0d_data16", k), 32'(if16.joy_data), 32'd1);
            check($sformatf("post_rst_p%0d_data8", k), 32'(if8.joy_data), 32'd1);
            check($sformatf("post_rst_p%0d_bitcnt16", k), 32'(if16.bit_cnt), 32'd0);
            check($sformatf("post_rst_p%0d_active16", k), 32'(if16.active), 32'd0);
        end
        p16 = poll16_n;
        latch(12'hFFF);
        check("relatch_data16", 32'(if16.joy_data), 32'd0);
        check("relatch_data8", 32'(if8.joy_data), 32'd0);
        check("relatch_active16", 32'(if16.active), 32'd1);
        check("relatch_polled16", 32'(poll16_n - p16), 32'd1);

        // Timeout: active falls 100 cycles after the last poll pulse.
        strb_s = 1'b1;
        wait_cyc(STRB_CYC);
        strb_s = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!seen && if16.polled) begin
                seen = 1'b1;
                break;
            end
        end
        check("timeout_poll_seen", 32'(seen), 32'd1);
        @(negedge clk);
        check("timeout_active_after_poll16", 32'(if16.active), 32'd1);
        repeat (99) @(negedge clk);
        check("timeout_active_at_99_16", 32'(if16.active), 32'd1);
        check("timeout_active_at_99_8", 32'(if8.active), 32'd1);
        @(negedge clk);
        check("timeout_active_at_100_16", 32'(if16.active), 32'd0);
        check("timeout_active_at_100_8", 32'(if8.active), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
